// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Packed-BCD price type shared by the order-book blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int PRICE_INT_DIGITS  = 4;
  localparam int PRICE_FRAC_DIGITS = 2;
  localparam int PRICE_W           = 4 * (PRICE_INT_DIGITS + PRICE_FRAC_DIGITS);

  // Fixed-point BCD, e.g. 100.25 is 24'h0100_25
  typedef logic [PRICE_W-1:0] price_t;

endpackage

`default_nettype wire

// File: rtl/ob_pkg.sv
// ============================================================================
// Module   : ob_pkg
// Brief    : Order-book table entry and reject-response types.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ob_pkg;

  localparam int UID_W = 16;
  localparam int QTY_W = 16;

  localparam int REJECT_DRAIN_DEPTH = 4;

  typedef logic [UID_W-1:0] uid_t;
  typedef logic [QTY_W-1:0] quantity_t;

  typedef struct packed {
    uid_t            uid;
    quantity_t       quantity;
    bcd_pkg::price_t price;
  } table_t;

  typedef struct packed {
    uid_t            uid;
    quantity_t       quantity;
    bcd_pkg::price_t price;
    logic            is_ask;
  } reject_rsp_t;

endpackage

`default_nettype wire

// File: rtl/ob_reject_drain_pkg.sv
// ============================================================================
// Module   : ob_reject_drain_pkg
// Brief    : Drain-local constants and the saturating counter helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ob_reject_drain_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == C_CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ob_reject_drain_if.sv
// ============================================================================
// Module   : ob_reject_drain_if
// Brief    : Table-side reject handshake plus downstream response handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ob_reject_drain_if #(
  parameter int DEPTH = 4
) ();
  import ob_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              reject_valid_r;
  table_t            reject_r;
  logic              reject_pop;
  logic              rsp_vld_r;
  reject_rsp_t       rsp_r;
  logic              rsp_accept;
  logic [OCC_W-1:0]  occupancy_r;
  logic [31:0]       reject_cnt_r;

  modport master (
    output reject_valid_r, reject_r, rsp_accept,
    input  reject_pop, rsp_vld_r, rsp_r, occupancy_r, reject_cnt_r
  );

  modport slave (
    input  reject_valid_r, reject_r, rsp_accept,
    output reject_pop, rsp_vld_r, rsp_r, occupancy_r, reject_cnt_r
  );

endinterface

`default_nettype wire

// File: rtl/ob_fifo_n.sv
// ============================================================================
// Module   : ob_fifo_n
// Brief    : Generic power-of-two FIFO with explicit occupancy tracking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ob_fifo_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             w_push;
  logic             w_pop;

  assign full_o      = (occ_q == C_DEPTH);
  assign empty_o     = (occ_q == '0);
  assign w_push      = push_i & ~full_o;
  assign w_pop       = pop_i & ~empty_o;
  assign head_o      = mem_q[rd_ptr_q];
  assign occupancy_o = occ_q;

  // Pointers wrap by natural overflow since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (w_push && !w_pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!w_push && w_pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ob_reject_drain.sv
// ============================================================================
// Module   : ob_reject_drain
// Brief    : Pops table rejects into a FIFO and replays them as responses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ob_reject_drain
  import ob_pkg::*;
  import ob_reject_drain_pkg::*;
#(
  parameter int   DEPTH  = REJECT_DRAIN_DEPTH,
  parameter logic is_ask = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  ob_reject_drain_if.slave   bus
);

  localparam int RSP_W = $bits(reject_rsp_t);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              w_push;
  logic              w_transfer;
  logic              w_full;
  logic              w_empty;
  logic [OCC_W-1:0]  w_occ;
  logic [RSP_W-1:0]  w_head;
  reject_rsp_t       w_push_data;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Full blocks a push even if a transfer happens this cycle: no accept-to-pop path
  assign w_push         = rst_n & bus.reject_valid_r & ~w_full;
  assign w_transfer     = ~w_empty & bus.rsp_accept;
  assign bus.reject_pop = w_push;

  always_comb begin
    w_push_data          = '0;
    w_push_data.uid      = bus.reject_r.uid;
    w_push_data.quantity = bus.reject_r.quantity;
    w_push_data.price    = bus.reject_r.price;
    w_push_data.is_ask   = is_ask;
  end

  ob_fifo_n #(
    .WIDTH (RSP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_transfer),
    .head_o      (w_head),
    .occupancy_o (w_occ),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  assign bus.rsp_vld_r   = ~w_empty;
  assign bus.rsp_r       = reject_rsp_t'(w_head);
  assign bus.occupancy_r = w_occ;

  always_comb begin
    cnt_d = cnt_q;
    if (w_push) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.reject_cnt_r = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ob_reject_drain.sv
// ============================================================================
// Module   : tb_ob_reject_drain
// Brief    : Directed vector table plus hand sequences for ob_reject_drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ob_reject_drain;
  import ob_pkg::*;

  localparam int DEPTH = 4;
  localparam int NV    = 18;

  typedef struct {
    logic        v;
    logic [15:0] uid;
    logic        acc;
    logic        e_pop;
    logic        e_vld;
    logic [15:0] e_uid;
    logic [2:0]  e_occ;
    logic [31:0] e_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  vec_t vt[NV];

  ob_reject_drain_if #(.DEPTH(DEPTH)) u_if ();

  ob_reject_drain #(.DEPTH(DEPTH), .is_ask(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic table_t mk_entry(input logic [15:0] uid);
    table_t t;
    t.uid = uid;
    if (uid == 16'd7) begin
      t.quantity = 16'd10;
      t.price    = 24'h010025;
    end else begin
      t.quantity = uid * 16'd2 + 16'd1;
      t.price    = 24'h000100 + {8'h00, uid};
    end
    return t;
  endfunction

  function automatic reject_rsp_t exp_rsp(input logic [15:0] uid);
    table_t t;
    reject_rsp_t r;
    t = mk_entry(uid);
    r.uid      = t.uid;
    r.quantity = t.quantity;
    r.price    = t.price;
    r.is_ask   = 1'b1;
    return r;
  endfunction

  function automatic vec_t row(input logic v, input logic [15:0] uid, input logic acc,
                               input logic e_pop, input logic e_vld, input logic [15:0] e_uid,
                               input logic [2:0] e_occ, input logic [31:0] e_cnt);
    vec_t r;
    r.v = v; r.uid = uid; r.acc = acc; r.e_pop = e_pop; r.e_vld = e_vld;
    r.e_uid = e_uid; r.e_occ = e_occ; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] uid, input logic acc);
    u_if.reject_valid_r = v;
    u_if.reject_r       = mk_entry(uid);
    u_if.rsp_accept     = acc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    vt[0]  = row(0, 0, 1, 0, 0, 0, 0, 0);
    vt[1]  = row(0, 0, 1, 0, 0, 0, 0, 0);
    vt[2]  = row(1, 7, 1, 1, 0, 0, 0, 0);
    vt[3]  = row(0, 0, 1, 0, 1, 7, 1, 1);
    vt[4]  = row(0, 0, 1, 0, 0, 0, 0, 1);
    vt[5]  = row(1, 1, 0, 1, 0, 0, 0, 1);
    vt[6]  = row(1, 2, 0, 1, 1, 1, 1, 2);
    vt[7]  = row(1, 3, 0, 1, 1, 1, 2, 3);
    vt[8]  = row(1, 4, 0, 1, 1, 1, 3, 4);
    vt[9]  = row(1, 5, 0, 0, 1, 1, 4, 5);
    vt[10] = row(1, 5, 0, 0, 1, 1, 4, 5);
    vt[11] = row(1, 5, 1, 0, 1, 1, 4, 5);
    vt[12] = row(1, 5, 1, 1, 1, 2, 3, 5);
    vt[13] = row(1, 6, 1, 1, 1, 3, 3, 6);
    vt[14] = row(0, 0, 1, 0, 1, 4, 3, 7);
    vt[15] = row(0, 0, 1, 0, 1, 5, 2, 7);
    vt[16] = row(0, 0, 1, 0, 1, 6, 1, 7);
    vt[17] = row(0, 0, 1, 0, 0, 0, 0, 7);

    // Reset state, with the table presenting a reject that must not be popped
    rst_n = 1'b0;
    drive(1'b1, 16'd99, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pop", 64'(u_if.reject_pop), 64'd0);
    chk("reset_vld", 64'(u_if.rsp_vld_r), 64'd0);
    chk("reset_occ", 64'(u_if.occupancy_r), 64'd0);
    chk("reset_cnt", 64'(u_if.reject_cnt_r), 64'd0);
    drive(1'b0, 16'd0, 1'b1);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].v, vt[i].uid, vt[i].acc);
      @(negedge clk);
      chk($sformatf("vec%0d_pop", i), 64'(u_if.reject_pop), 64'(vt[i].e_pop));
      chk($sformatf("vec%0d_vld", i), 64'(u_if.rsp_vld_r), 64'(vt[i].e_vld));
      chk($sformatf("vec%0d_occ", i), 64'(u_if.occupancy_r), 64'(vt[i].e_occ));
      chk($sformatf("vec%0d_cnt", i), 64'(u_if.reject_cnt_r), 64'(vt[i].e_cnt));
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d_rsp", i), 64'(u_if.rsp_r), 64'(exp_rsp(vt[i].e_uid)));
      end
      next_cycle();
    end

    // Push and transfer together at occupancy 1, wrapping the pointers
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 16'(20 + k), 1'b1);
      @(negedge clk);
      chk($sformatf("str%0d_pop", k), 64'(u_if.reject_pop), 64'd1);
      chk($sformatf("str%0d_cnt", k), 64'(u_if.reject_cnt_r), 64'(7 + k));
      if (k > 0) begin
        chk($sformatf("str%0d_occ", k), 64'(u_if.occupancy_r), 64'd1);
        chk($sformatf("str%0d_rsp", k), 64'(u_if.rsp_r), 64'(exp_rsp(16'(19 + k))));
      end
      next_cycle();
    end
    drive(1'b0, 16'd0, 1'b1);
    @(negedge clk);
    chk("str_last_vld", 64'(u_if.rsp_vld_r), 64'd1);
    chk("str_last_rsp", 64'(u_if.rsp_r), 64'(exp_rsp(16'd29)));
    next_cycle();
    @(negedge clk);
    chk("str_end_occ", 64'(u_if.occupancy_r), 64'd0);
    chk("str_end_cnt", 64'(u_if.reject_cnt_r), 64'd17);
    next_cycle();

    // Fill to 3, then pulse reset between edges
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'(30 + k), 1'b0);
      next_cycle();
    end
    drive(1'b0, 16'd0, 1'b0);
    @(negedge clk);
    chk("pre_rst_occ", 64'(u_if.occupancy_r), 64'd3);
    chk("pre_rst_cnt", 64'(u_if.reject_cnt_r), 64'd20);
    next_cycle();
    drive(1'b1, 16'd33, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(u_if.rsp_vld_r), 64'd0);
    chk("arst_occ", 64'(u_if.occupancy_r), 64'd0);
    chk("arst_cnt", 64'(u_if.reject_cnt_r), 64'd0);
    chk("arst_pop", 64'(u_if.reject_pop), 64'd0);
    @(negedge clk);
    drive(1'b0, 16'd0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("post_rst%0d_vld", k), 64'(u_if.rsp_vld_r), 64'd0);
      chk($sformatf("post_rst%0d_occ", k), 64'(u_if.occupancy_r), 64'd0);
    end

    // Counter saturation
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b1, 16'(40 + k), 1'b1);
      else       drive(1'b0, 16'd0, 1'b1);
      @(negedge clk);
      chk($sformatf("sat%0d_cnt", k), 64'(u_if.reject_cnt_r),
          (k == 0) ? 64'hFFFF_FFFE : 64'hFFFF_FFFF);
      if (k > 0) begin
        chk($sformatf("sat%0d_rsp", k), 64'(u_if.rsp_r), 64'(exp_rsp(16'(39 + k))));
      end
      next_cycle();
    end
    drive(1'b0, 16'd0, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("sat_hold_cnt", 64'(u_if.reject_cnt_r), 64'hFFFF_FFFF);
    chk("sat_empty_vld", 64'(u_if.rsp_vld_r), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ob_reject_drain.md
# ob_reject_drain

Consumer for the order-book table's reject interface. It pops evicted (reject) entries from an `ob_table` instance as soon as they are presented and buffers them in a small FIFO. It emits each one downstream as a cancel/reject response under a valid/accept handshake, so the table never stalls on a slow response path. One instance sits beside each side's table (bid and ask).

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `is_ask`, default 'b1: side tag copied into every response (1 = ask table, 0 = bid table).

Ports:
- `clk`, in, 1: sole clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `reject_valid_r`, in, 1: table's reject slot holds a valid entry.
- `reject_r`, in, `ob_pkg::table_t`: table's reject entry (fields `uid`, `quantity`, `price` used).
- `reject_pop`, out, 1: combinational pop strobe to the table.
- `rsp_vld_r`, out, 1: response valid.
- `rsp_r`, out, `ob_pkg::reject_rsp_t`: response payload {`uid`, `quantity`, `price`, `is_ask`}.
- `rsp_accept`, in, 1: downstream takes the response this cycle.
- `occupancy_r`, out, $clog2(DEPTH+1): current FIFO fill level.
- `reject_cnt_r`, out, 32: total rejects drained; saturates at 32'hFFFF_FFFF.

## Operation

- Pop rule: `reject_pop = rst_n & reject_valid_r & ~full`.
  - `full` is `occupancy_r == DEPTH`.
  - It depends only on flops and `reject_valid_r`; there is no path from `rsp_accept`.
  - A dequeue in the same cycle does not free a slot for a push while full. This deliberately breaks the timing path.
- Push: in a cycle with `reject_pop`=1, the payload is written to `mem[wr_ptr]`:
  - `uid`, `quantity` and `price` come from `reject_r`;
  - `is_ask` comes from the parameter.
  - Then `wr_ptr` increments.
- Pop downstream:
  - `rsp_vld_r = (occupancy_r != 0)` and `rsp_r = mem[rd_ptr]`; both are flop-derived.
  - A transfer occurs when `rsp_vld_r & rsp_accept`; `rd_ptr` then increments.
  - `rsp_accept` while `rsp_vld_r`=0 is ignored.
- Pointers:
  - width $clog2(DEPTH); wrap modulo DEPTH with natural overflow.
  - `occupancy_r` is tracked explicitly: +1 on push only, −1 on transfer only, unchanged on both or neither.
- Simultaneous push and transfer (not full): both proceed and occupancy is unchanged.
  - With occupancy 1, the new entry becomes head the next cycle, behind the entry transferred this cycle.
- Payload stability: `rsp_r` is held stable while `rsp_vld_r`=1 and `rsp_accept`=0.
- Ordering: strictly FIFO, in the order the table evicted the entries.
- Counter: `reject_cnt_r` increments on each push and holds at all-ones.
- The block has no FSM beyond the FIFO pointers and occupancy. The empty/partial/full states are derived from occupancy.

## Timing

- Reset (`rst_n` low, async):
  - `rsp_vld_r`=0, `occupancy_r`=0, `reject_cnt_r`=0, pointers 0;
  - `reject_pop` is forced 0 combinationally;
  - `mem` is not reset, and `rsp_r` is don't-care while `rsp_vld_r`=0.
- Reset release is synchronous to `clk` by integration; the first push can occur in the first cycle after deassertion.
- Latency: a reject popped in cycle N appears on `rsp_vld_r`/`rsp_r` in cycle N+1 (empty FIFO, no bypass).
- Throughput:
  - one push per cycle and one transfer per cycle sustained while not full;
  - with `rsp_accept` tied high, occupancy never exceeds 1.
- Table side: after `reject_pop`, the table deasserts or refreshes `reject_valid_r` by the next cycle. Back-to-back pops on consecutive cycles are legal.
- Reset mid-operation: buffered entries are discarded, and no response is emitted for them after release.

## Structure

- `ob_pkg` additions:
  - typedef `reject_rsp_t` {`uid_t uid`, `quantity_t quantity`, `bcd_pkg::price_t price`, `logic is_ask`};
  - constant `REJECT_DRAIN_DEPTH` = 4 for top-level instantiation.
- Natural sub-module: `ob_fifo_n` (generic parameterized FIFO: `WIDTH`, `DEPTH`, push/pop/occupancy, async active-low reset). `ob_reject_drain` wraps it with the pop rule, payload formatting and the counter.

## Test plan

- Single reject:
  - Stimulus: `reject_valid_r` pulses 1 cycle at cycle 5 with uid=7, price=100.25, qty=10; `rsp_accept`=1.
  - Required: `reject_pop`=1 at cycle 5; `rsp_vld_r`=1 at cycle 6 only, with uid=7, price=100.25, qty=10, is_ask=1; `reject_cnt_r`=1.
- Backpressure to full:
  - Stimulus: `rsp_accept`=0 with 6 consecutive rejects uid=1..6, DEPTH=4.
  - Required: `reject_pop` for uid 1..4 only; `occupancy_r`=4; `reject_pop`=0 while `reject_valid_r` stays 1 with uid=5.
- Drain from full:
  - Stimulus: continuing the previous scenario, assert `rsp_accept`=1.
  - Required: responses emitted in order uid=1,2,3,4,5,6; the pop of uid=5 occurs in the cycle after the first transfer, never in the same cycle while full.
- Simultaneous push and transfer at occupancy 1:
  - Required: occupancy stays 1; the next head is the new entry; pointer wrap is exercised over 10 entries with no loss or duplication.
- Mid-stream async reset:
  - Stimulus: `rst_n` low for half a cycle with occupancy 3.
  - Required: `rsp_vld_r`, `occupancy_r` and `reject_cnt_r` go 0 immediately (asynchronously, without waiting for a clock edge); `reject_pop` is 0 while `rst_n` is low.
- Counter saturation:
  - Stimulus: force `reject_cnt_r` to 32'hFFFF_FFFE, then drain 3 rejects.
  - Required: reads 32'hFFFF_FFFF and holds.
